decode_stage: RTL

Consumer end of the fetch→decode handshake. Accepts one fetched RV32I instruction per cycle with its PC and PC+4, decodes it into register indices, sign-extended immediate, and control flags, and presents the result from a single-entry pipeline register to rename. It drives the ready that throttles fetch, so backpressure from rename propagates upstream with no loss or duplication. A flush input discards in-flight work on a redirect.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/decode_stage_if.sv | 24 ++
 rtl/instr_decoder.sv | 61 ++++++
 rtl/decode_stage.sv | 50 +++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode constants, ALU op encoding and the decoded-instruction bundle
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;
  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    alu_op_t         alu_op;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_load;
    logic            is_store;
    logic            is_lui;
    logic            is_auipc;
    logic [2:0]      funct3;
    logic            illegal;
  } decoded_t;
  // alt selects SUB on funct3=000 and SRA on funct3=101 (instr[30])
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch->decode handshake and decoded outputs toward rename
interface decode_stage_if import riscv_pkg::*; ;
  logic [XLEN-1:0] instr_in, pc_in, pc_4_in;
  logic            valid_in, ready_in, flush, ready_out, valid_out;
  logic [XLEN-1:0] pc_out, pc_4_out, imm;
  logic [4:0]      rs1, rs2, rd;
  alu_op_t         alu_op;
  logic            uses_rs1, uses_rs2, writes_rd;
  logic            is_branch, is_jal, is_jalr, is_load, is_store, is_lui, is_auipc;
  logic [2:0]      funct3;
  logic            illegal;
  modport master(
    output instr_in, pc_in, pc_4_in, valid_in, flush, ready_out,
    input  ready_in, valid_out, pc_out, pc_4_out, rs1, rs2, rd, imm, alu_op,
           uses_rs1, uses_rs2, writes_rd, is_branch, is_jal, is_jalr, is_load,
           is_store, is_lui, is_auipc, funct3, illegal
  );
  modport slave(
    input  instr_in, pc_in, pc_4_in, valid_in, flush, ready_out,
    output ready_in, valid_out, pc_out, pc_4_out, rs1, rs2, rd, imm, alu_op,
           uses_rs1, uses_rs2, writes_rd, is_branch, is_jal, is_jalr, is_load,
           is_store, is_lui, is_auipc, funct3, illegal
  );
endinterface

// File: rtl/instr_decoder.sv
// instr_decoder: combinational RV32I instruction word -> decoded_t
module instr_decoder import riscv_pkg::*; (
  input  logic [XLEN-1:0] instr,
  output decoded_t        dec
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic op_ok, sh_ok;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign op_ok = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
  assign sh_ok = f3 == 3'b001 ? f7 == 7'b0 :
                 f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
  always_comb begin
    dec        = '0;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.funct3 = f3;
    dec.alu_op = ALU_ADD;
    case (opc)
      OPC_LUI:    begin dec.imm = imm_u; dec.writes_rd = 1'b1; dec.is_lui = 1'b1; dec.alu_op = ALU_PASS_B; end
      OPC_AUIPC:  begin dec.imm = imm_u; dec.writes_rd = 1'b1; dec.is_auipc = 1'b1; end
      OPC_JAL:    begin dec.imm = imm_j; dec.writes_rd = 1'b1; dec.is_jal = 1'b1; end
      OPC_JALR:   begin dec.imm = imm_i; dec.uses_rs1 = 1'b1; dec.writes_rd = 1'b1; dec.is_jalr = 1'b1; end
      OPC_BRANCH: begin dec.imm = imm_b; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.is_branch = 1'b1; dec.alu_op = ALU_SUB; end
      OPC_LOAD:   begin dec.imm = imm_i; dec.uses_rs1 = 1'b1; dec.writes_rd = 1'b1; dec.is_load = 1'b1; end
      OPC_STORE:  begin dec.imm = imm_s; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; dec.is_store = 1'b1; end
      OPC_OP_IMM: begin
        dec.imm       = imm_i;
        dec.uses_rs1  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.alu_op    = alu_from_f3(f3, f3 == 3'b101 && instr[30]);
        dec.illegal   = !sh_ok;
      end
      OPC_OP: begin
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.alu_op    = alu_from_f3(f3, instr[30]);
        dec.illegal   = !op_ok;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.imm       = '0;
      dec.alu_op    = ALU_ADD;
      dec.uses_rs1  = 1'b0;
      dec.uses_rs2  = 1'b0;
      dec.writes_rd = 1'b0;
    end
    dec.writes_rd = dec.writes_rd && dec.rd != 5'd0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: single-entry decode pipeline register between fetch and rename
module decode_stage import riscv_pkg::*; (
  input logic clk,
  input logic reset,
  decode_stage_if.slave d
);
  decoded_t dec, q;
  logic [XLEN-1:0] pc_q, pc4_q;
  logic v;
  instr_decoder u_dec (.instr(d.instr_in), .dec(dec));
  // flush always accepts so the redirected fetch never stalls on a dead entry
  assign d.ready_in = d.flush || !v || d.ready_out;
  always_ff @(posedge clk) begin
    if (reset) begin
      v     <= 1'b0;
      q     <= '0;
      pc_q  <= '0;
      pc4_q <= '0;
    end else if (d.flush) begin
      v <= 1'b0;
    end else if (d.valid_in && d.ready_in) begin
      v     <= 1'b1;
      q     <= dec;
      pc_q  <= d.pc_in;
      pc4_q <= d.pc_4_in;
    end else if (d.ready_out) begin
      v <= 1'b0;
    end
  end
  assign d.valid_out = v;
  assign d.pc_out    = pc_q;
  assign d.pc_4_out  = pc4_q;
  assign d.rs1       = q.rs1;
  assign d.rs2       = q.rs2;
  assign d.rd        = q.rd;
  assign d.imm       = q.imm;
  assign d.alu_op    = q.alu_op;
  assign d.uses_rs1  = q.uses_rs1;
  assign d.uses_rs2  = q.uses_rs2;
  assign d.writes_rd = q.writes_rd;
  assign d.is_branch = q.is_branch;
  assign d.is_jal    = q.is_jal;
  assign d.is_jalr   = q.is_jalr;
  assign d.is_load   = q.is_load;
  assign d.is_store  = q.is_store;
  assign d.is_lui    = q.is_lui;
  assign d.is_auipc  = q.is_auipc;
  assign d.funct3    = q.funct3;
  assign d.illegal   = q.illegal;
endmodule
